sseg_scan_driver: RTL and testbench
===================================

// Module: sseg_scan_driver
// PURPOSE
//   Parametrised multiplexed seven-segment display driver for the motherboard's display path.
//   Scans N_DIGITS hex digits onto one shared segment bus with per-digit anode select.
//   Adds per-digit blanking, decimal points, selectable pin polarity and a tear-free
//   shadow-register load. New values commit only at frame boundaries.
// PARAMETERS
//   N_DIGITS    4   number of digits scanned (>=2)
//   DIV_WIDTH   16  refresh divider width; digit dwell = 2**DIV_WIDTH clk cycles
//   ACTIVE_LOW  1   1: an/seg/dp pins driven active-low; 0: active-high
// PORTS
//   clk         in   1           system clock
//   rst         in   1           synchronous reset, active-high
//   load        in   1           1-cycle strobe: capture value/blank_mask/dp_mask into pending
//   value       in   4*N_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost
//   blank_mask  in   N_DIGITS    1 = digit i dark (anode never asserted)
//   dp_mask     in   N_DIGITS    1 = decimal point lit while digit i selected
//   pending     out  1           1 = a loaded value awaits commit at next frame boundary
//   frame_tick  out  1           1-cycle pulse when scan wraps from digit N_DIGITS-1 to 0
//   an          out  N_DIGITS    one-hot anode select (polarity per ACTIVE_LOW)
//   seg         out  7           segments {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
//   dp          out  1           decimal point (polarity per ACTIVE_LOW)
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): div_cnt=0, digit_idx=0, active value/blank/dp regs=0,
//     pending=0, frame_tick=0, an/seg/dp = all inactive level. Reset mid-frame discards
//     any pending load and restarts the scan at digit 0.
//   - Divider: div_cnt increments every clk and wraps from 2**DIV_WIDTH-1 to 0.
//     step = (div_cnt == all-ones). On step, digit_idx advances; at N_DIGITS-1 it wraps to 0.
//   - Frame boundary = step with digit_idx==N_DIGITS-1. frame_tick=1 the cycle after that edge.
//     If pending=1 at that edge, active regs <= pending regs and pending <= 0 on the same edge.
//   - load: on the edge where load=1, pending regs <= inputs and pending <= 1.
//     Load while pending=1 overwrites the pending regs (last wins).
//     Load on a frame-boundary edge: active gets the OLD pending contents; the new inputs
//     become pending and pending stays 1. Load with pending=0 on a boundary edge does not
//     commit until the following boundary.
//   - Outputs are registered, one cycle after digit_idx/active change:
//     an[i] asserted iff i==digit_idx and !blank[i]; all others deasserted.
//     seg = hex glyph of active nibble[digit_idx]; all segments off when that digit is blanked.
//     dp asserted iff dp_mask[digit_idx] and the digit is not blanked.
//   - Glyph table (gfedcba, active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//     8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. ACTIVE_LOW=1 inverts an, seg and dp at the pins.
//   - Exactly one anode is asserted at a time, or none; an is never multi-hot, even across
//     digit transitions.
// TESTING (DIV_WIDTH=2, N_DIGITS=4, ACTIVE_LOW=1 unless noted)
//   1 Reset: hold rst 3 cycles -> an=4'hF, seg=7'h7F, dp=1, pending=0. Release ->
//     next cycle an=4'hE, seg=~7'h3F (digit0 shows '0').
//   2 Scan order: free-run 16 cycles -> an sequence E,D,B,7, each held 4 cycles;
//     frame_tick pulses once per 16 cycles.
//   3 Tear-free load: load value=16'h1A2F mid-frame -> pending=1; display unchanged until
//     the boundary; then digits show F,2,A,1; pending=0.
//   4 Load collision: load 16'h1111, then load 16'h2222 on the boundary edge -> that frame
//     shows 1111, pending stays 1, next frame shows 2222.
//   5 Blank/dp: blank_mask=4'b0100, dp_mask=4'b0001 -> an never 4'hB; dp=0 only while an=4'hE.
//   6 Reset mid-operation: rst with pending=1 mid-frame -> pending=0, digit_idx restarts at 0,
//     active=0. ACTIVE_LOW=0 run -> pin levels inverted vs. scenario 2.

Source files
------------

// File: rtl/sseg_scan_driver.sv
// Multiplexed N-digit hex seven-segment scanner with shadow-register load committed at frame boundaries.
// Pins are registered one cycle behind digit_idx/active state; polarity is selected by ACTIVE_LOW.
module sseg_scan_driver #(
  parameter int N_DIGITS   = 4,
  parameter int DIV_WIDTH  = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int   IW  = $clog2(N_DIGITS);
  localparam logic POL = (ACTIVE_LOW != 0);

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [IW-1:0]         digit_idx_q, digit_idx_d;
  logic [4*N_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                  pending_q, pending_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  step, boundary, blanked;
  logic [3:0]            nib;
  logic [N_DIGITS-1:0]   an_lvl;
  logic [6:0]            seg_lvl;
  logic                  dp_lvl;

  always_comb begin
    div_d       = div_q + 1'b1;
    step        = &div_q;
    boundary    = step && (digit_idx_q == IW'(N_DIGITS - 1));
    digit_idx_d = digit_idx_q;
    if (step) digit_idx_d = boundary ? '0 : digit_idx_q + 1'b1;
    frame_tick_d = boundary;

    // Commit uses the pending contents from before this edge; a coincident load refills pending.
    act_val_d   = act_val_q;
    act_blank_d = act_blank_q;
    act_dp_d    = act_dp_q;
    pending_d   = pending_q;
    if (boundary && pending_q) begin
      act_val_d   = pend_val_q;
      act_blank_d = pend_blank_q;
      act_dp_d    = pend_dp_q;
      pending_d   = 1'b0;
    end
    pend_val_d   = pend_val_q;
    pend_blank_d = pend_blank_q;
    pend_dp_d    = pend_dp_q;
    if (load) begin
      pend_val_d   = value;
      pend_blank_d = blank_mask;
      pend_dp_d    = dp_mask;
      pending_d    = 1'b1;
    end

    nib     = act_val_q[digit_idx_q*4 +: 4];
    blanked = act_blank_q[digit_idx_q];
    an_lvl  = blanked ? '0 : (N_DIGITS'(1) << digit_idx_q);
    seg_lvl = blanked ? 7'h00 : glyph(nib);
    dp_lvl  = act_dp_q[digit_idx_q] && !blanked;
    an_d    = an_lvl ^ {N_DIGITS{POL}};
    seg_d   = seg_lvl ^ {7{POL}};
    dp_d    = dp_lvl ^ POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      digit_idx_q  <= '0;
      act_val_q    <= '0;
      act_blank_q  <= '0;
      act_dp_q     <= '0;
      pend_val_q   <= '0;
      pend_blank_q <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= {N_DIGITS{POL}};
      seg_q        <= {7{POL}};
      dp_q         <= POL;
    end else begin
      div_q        <= div_d;
      digit_idx_q  <= digit_idx_d;
      act_val_q    <= act_val_d;
      act_blank_q  <= act_blank_d;
      act_dp_q     <= act_dp_d;
      pend_val_q   <= pend_val_d;
      pend_blank_q <= pend_blank_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: two instances (active-low and active-high pins) share one stimulus
// stream; a frame-level model predicts each cycle's display and a negedge monitor checks it.
module tb_sseg_scan_driver;

  localparam int N  = 4;
  localparam int DW = 2;
  localparam int D  = 1 << DW;   // dwell per digit
  localparam int F  = D * N;     // cycles per frame

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  dp_mask = '0;

  logic        pend_lo, ft_lo, dp_lo, pend_hi, ft_hi, dp_hi;
  logic [3:0]  an_lo, an_hi;
  logic [6:0]  seg_lo, seg_hi;

  sseg_scan_driver #(.N_DIGITS(N), .DIV_WIDTH(DW), .ACTIVE_LOW(1)) u_dut_lo (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
    .dp_mask(dp_mask), .pending(pend_lo), .frame_tick(ft_lo), .an(an_lo), .seg(seg_lo), .dp(dp_lo));

  sseg_scan_driver #(.N_DIGITS(N), .DIV_WIDTH(DW), .ACTIVE_LOW(0)) u_dut_hi (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
    .dp_mask(dp_mask), .pending(pend_hi), .frame_tick(ft_hi), .an(an_hi), .seg(seg_hi), .dp(dp_hi));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;     // logical (1 = lit) levels
    logic [6:0] seg;
    logic       dp;
    logic       pend;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: cycles since reset plus the displayed and waiting frame contents.
  int          cyc = 0;
  logic [15:0] a_val = '0, p_val = '0;
  logic [3:0]  a_bl = '0, a_dp = '0, p_bl = '0, p_dp = '0;
  logic        pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cyc_step(input logic r, input logic l, input logic [15:0] v,
                          input logic [3:0] bm, input logic [3:0] dm);
    exp_t e;
    int   d;
    bit   bnd;
    #1;
    rst = r; load = l; value = v; blank_mask = bm; dp_mask = dm;
    @(posedge clk);
    if (r) begin
      e.an = '0; e.seg = '0; e.dp = 1'b0; e.pend = 1'b0; e.ft = 1'b0;
      cyc = 0; a_val = '0; a_bl = '0; a_dp = '0; p_val = '0; p_bl = '0; p_dp = '0; pend = 1'b0;
    end else begin
      d    = (cyc / D) % N;
      e.an = a_bl[d] ? 4'h0 : 4'(1 << d);
      e.seg = a_bl[d] ? 7'h00 : glyph_tab[a_val[d*4 +: 4]];
      e.dp = a_dp[d] && !a_bl[d];
      bnd  = (cyc % F) == F - 1;
      e.ft = bnd;
      if (bnd && pend) begin
        a_val = p_val; a_bl = p_bl; a_dp = p_dp; pend = 1'b0;
      end
      if (l) begin
        p_val = v; p_bl = bm; p_dp = dm; pend = 1'b1;
      end
      e.pend = pend;
      cyc++;
    end
    exp_q.push_back(e);
  endtask

  // Idle cycles drive random data with load low; it must be ignored.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      cyc_step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic to_boundary();
    while ((cyc % F) != F - 1) idle(1);
  endtask

  // Monitor: checks both pin polarities against each popped expectation.
  initial begin
    exp_t       e;
    logic [3:0] an_x;
    logic [6:0] seg_x;
    logic       dp_x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e     = exp_q.pop_front();
        an_x  = e.an ^ 4'hF;
        seg_x = e.seg ^ 7'h7F;
        dp_x  = ~e.dp;
        chk("an_lo", an_lo, an_x);
        chk("seg_lo", seg_lo, seg_x);
        chk("dp_lo", dp_lo, dp_x);
        chk("pending_lo", pend_lo, e.pend);
        chk("frame_tick_lo", ft_lo, e.ft);
        chk("an_hi", an_hi, e.an);
        chk("seg_hi", seg_hi, e.seg);
        chk("dp_hi", dp_hi, e.dp);
        chk("pending_hi", pend_hi, e.pend);
        chk("frame_tick_hi", ft_hi, e.ft);
        chk("an_onehot0", ($countones(an_hi) <= 1), 1);
      end
    end
  end

  initial begin
    // Reset held three cycles, then free-run two frames.
    for (int k = 0; k < 3; k++) cyc_step(1'b1, 1'b0, '0, '0, '0);
    idle(2 * F + 3);

    // Tear-free load mid-frame, observed through the next two frames.
    idle(5);
    cyc_step(1'b0, 1'b1, 16'h1A2F, 4'h0, 4'h0);
    idle(2 * F);

    // Load collision: second load lands exactly on the boundary edge.
    idle(3);
    cyc_step(1'b0, 1'b1, 16'h1111, 4'h0, 4'h0);
    to_boundary();
    cyc_step(1'b0, 1'b1, 16'h2222, 4'h0, 4'h0);
    idle(2 * F);

    // Load with pending low exactly on a boundary edge waits a full frame.
    to_boundary();
    cyc_step(1'b0, 1'b1, 16'h5A3C, 4'h0, 4'h0);
    idle(2 * F);

    // Blanking and decimal points.
    cyc_step(1'b0, 1'b1, 16'h9876, 4'b0100, 4'b0001);
    idle(3 * F);

    // Reset mid-frame with a load pending.
    to_boundary();
    idle(3);
    cyc_step(1'b0, 1'b1, 16'hBEEF, 4'h0, 4'hF);
    idle(2);
    cyc_step(1'b1, 1'b0, '0, '0, '0);
    idle(2 * F);

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 800; k++)
      cyc_step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
               16'($urandom), 4'($urandom), 4'($urandom));

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
